mips_run_ctrl: RTL
==================

# mips_run_ctrl

Session controller for the pipelined MIPS core. It streams a program image into the core's memory while the core is held in reset, then releases the core and counts cycles until `halted`. It then streams a selected range of architectural registers out over a valid/ready port. It sits between a host/bench stream interface and the core's memory-write and register-debug-read ports, replacing ad hoc hierarchical preloading and peeking.

## Interface
- `ADDR_W`, 10: memory word-address width; depth = 2**ADDR_W.
- `TIMEOUT`, 4096: maximum RUN cycles before the session is aborted.

- `clk1`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  session start request; sampled only in IDLE.
- `load_len`  in  ADDR_W+1  words to load; 0 skips LOAD; values > 2**ADDR_W saturate to 2**ADDR_W.
- `dump_first`, `dump_last`  in  5 each  inclusive register range to dump.
- `in_valid`  in  1 / `in_data`  in  32 / `in_ready`  out  1  program word stream.
- `mem_we`  out  1 / `mem_addr`  out  ADDR_W / `mem_wdata`  out  32  core memory write port.
- `core_rst`  out  1  holds the core pipeline in reset.
- `core_run`  out  1  core clock-enable.
- `halted`  in  1  core HLT retired.
- `reg_raddr`  out  5 / `reg_rdata`  in  32  core register debug read; combinational, same cycle.
- `out_valid`  out  1 / `out_data`  out  32 / `out_ready`  in  1  register dump stream.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at session end.
- `timeout_err`  out  1  sticky; cleared when the next session is accepted.
- `cycle_count`  out  32  RUN cycles of the current or last session.

## Operation
- States: IDLE, LOAD, RUN, DUMP, DONE.
- **IDLE:** `core_rst`=1, `core_run`=0, `in_ready`=0, `out_valid`=0.
  - On `start`=1: latch `load_len`, `dump_first`, `dump_last`; clear `cycle_count` and `timeout_err`; clear the address pointer.
  - Next state is LOAD, or RUN if `load_len`=0.
- **LOAD:** `in_ready`=1, `core_rst`=1.
  - Each cycle with `in_valid`&`in_ready`: `mem_we`=1, `mem_addr`=pointer, `mem_wdata`=`in_data` (combinational from the handshake); the pointer then increments.
  - After the word at pointer `load_len`−1 is accepted, go to RUN.
  - `in_valid` low stalls the state with no write.
  - At saturated length the pointer wraps to 0 exactly when leaving LOAD; no extra write occurs.
- **RUN:** `core_rst`=0, `core_run`=1.
  - `cycle_count` increments on every edge in RUN with `halted`=0.
  - `halted`=1 → DUMP.
  - `cycle_count` reaching `TIMEOUT` → set `timeout_err`, go to DUMP.
  - `halted` and timeout in the same cycle: halt wins, no error.
- **DUMP:** `core_run`=0, `core_rst`=0, so the register file is preserved.
  - `reg_raddr`=register pointer, initialised to `dump_first`.
  - `out_valid`=1 and `out_data`=`reg_rdata`.
  - On `out_ready`, the pointer increments. After `dump_last` is accepted, go to DONE.
  - `dump_first` > `dump_last`: no words are emitted; DUMP lasts one cycle with `out_valid`=0, then DONE.
  - `out_data` is held stable while `out_valid`&!`out_ready`.
- **DONE:** `done`=1 for one cycle, then IDLE.
- `start` while `busy` is ignored.
- `in_valid` outside LOAD is ignored.
- `halted` outside RUN is ignored.
- Outside LOAD, `mem_we`=0 and `mem_addr`/`mem_wdata` are 0.
- Outside DUMP, `out_data`=0 and `reg_raddr`=0.

## Timing
- Reset values: state IDLE; `core_rst`=1; `busy`=0; `done`=0; `timeout_err`=0; `cycle_count`=0. All other outputs are 0.
- Reset asserted mid-session aborts immediately (asynchronous) to IDLE with all reset values. Partially loaded memory contents are left as written.
- `start` sampled at edge N → state LOAD/RUN after edge N; `busy`=1 from edge N.
- LOAD throughput: one word per cycle; L words take ≥ L cycles.
- First RUN cycle follows the edge on which the last word is accepted.
- `halted` seen at edge M → DUMP after edge M; `core_run`=0 from then on.
- DUMP throughput: one register per cycle with `out_ready` held high.
- Minimum session with `load_len`=0 and an empty range: IDLE→RUN→DUMP→DONE→IDLE.

## Test plan
- Load 17 words: ADDI R1,R0,1 at 0; ADDI R2,R0,2 at 4; SLT R3,R1,R2 at 8; SLT R4,R2,R1 at 12; NOPs elsewhere; HLT at 16. Dump R1..R4 → stream 1,2,1,0; `done` pulse; `timeout_err`=0; `cycle_count` > 16.
- Same program with `in_valid` toggling every other cycle and `out_ready` low for 3 cycles mid-dump → identical memory contents and stream; `out_data` held while stalled.
- Program of NOPs only with `TIMEOUT`=64 → `cycle_count`=64, `timeout_err`=1, dump still completes, `done` pulses.
- `load_len`=0 with `dump_first`=5, `dump_last`=2 → no `mem_we`, zero `out_valid` cycles, `done` within 4 cycles of `start`.
- `rst` asserted in RUN and again mid-DUMP → all outputs return to reset values asynchronously. A following `start` completes a full, correct session.
- `start` pulsed during LOAD and during DUMP → ignored: latched `load_len` and register range unchanged, no second session.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: session controller for the pipelined MIPS core.
// Streams a program image into core memory while the core is held in reset,
// runs the core until it retires HLT (or a cycle budget expires), then streams
// a range of architectural registers out over a valid/ready port.
//
// Ports:
//   clk1, rst                       clock, asynchronous active-high reset
//   start, load_len                 session request and number of words to load
//   dump_first, dump_last           inclusive register range to dump
//   in_valid, in_data, in_ready     program word stream (accepted in LOAD only)
//   mem_we, mem_addr, mem_wdata     core memory write port
//   core_rst, core_run              core pipeline reset and clock enable
//   halted                          core has retired HLT
//   reg_raddr, reg_rdata            combinational register debug read
//   out_valid, out_data, out_ready  register dump stream
//   busy, done, timeout_err         status: not idle, end pulse, sticky timeout
//   cycle_count                     RUN cycles of the current or last session
module mips_run_ctrl #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [4:0]        dump_first,
  input  logic [4:0]        dump_last,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              core_run,
  input  logic              halted,
  output logic [4:0]        reg_raddr,
  input  logic [31:0]       reg_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDump, StDone} state_e;

  // Largest loadable image: the whole memory.
  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [4:0]        first_q, first_d;
  logic [4:0]        last_q, last_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [4:0]        rptr_q, rptr_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              terr_q, terr_d;

  logic [31:0]       cnt_inc;
  logic              range_empty;

  assign cnt_inc     = cnt_q + 32'd1;
  assign range_empty = first_q > last_q;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      ptr_q   <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      first_q <= first_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    first_d   = first_q;
    last_d    = last_q;
    ptr_d     = ptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q;

    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    core_rst  = 1'b1;
    core_run  = 1'b0;
    reg_raddr = '0;
    out_valid = 1'b0;
    out_data  = '0;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = (load_len > MaxLen) ? MaxLen : load_len;
          first_d = dump_first;
          last_d  = dump_last;
          ptr_d   = '0;
          rptr_d  = dump_first;
          cnt_d   = '0;
          terr_d  = 1'b0;
          state_d = (load_len == '0) ? StRun : StLoad;
        end
      end

      StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = ptr_q;
          mem_wdata = in_data;
          // At full-memory length this increment wraps the pointer to 0.
          ptr_d     = ptr_q + 1'b1;
          if ({1'b0, ptr_q} == len_q - 1'b1) begin
            state_d = StRun;
          end
        end
      end

      StRun: begin
        core_rst = 1'b0;
        core_run = 1'b1;
        // A halt in the same cycle as the budget expiring is not an error.
        if (halted) begin
          state_d = StDump;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT) begin
            terr_d  = 1'b1;
            state_d = StDump;
          end
        end
      end

      StDump: begin
        // Core frozen but out of reset so the register file stays intact.
        core_rst = 1'b0;
        if (range_empty) begin
          state_d = StDone;
        end else begin
          reg_raddr = rptr_q;
          out_valid = 1'b1;
          out_data  = reg_rdata;
          if (out_ready) begin
            rptr_d = rptr_q + 1'b1;
            if (rptr_q == last_q) begin
              state_d = StDone;
            end
          end
        end
      end

      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign timeout_err = terr_q;
  assign cycle_count = cnt_q;

endmodule
